// File: rtl/conv_mac_engine_if.sv
// Bus bundle between the convolution controller (master) and conv_mac_engine (slave).
// Carries the state strobes, the coefficient/sample streams and the status/result returns.
interface conv_mac_engine_if #(
    parameter int TAPS   = 4,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 2 * DATA_W + $clog2(TAPS)
);

    logic        [15:0]       frame_len;
    logic                     load_coeff;
    logic                     load_sample;
    logic                     start_conv;
    logic                     shift;
    logic signed [DATA_W-1:0] coeff_in;
    logic                     coeff_valid;
    logic signed [DATA_W-1:0] sample_in;
    logic                     sample_valid;
    logic                     coeff_loaded;
    logic                     sample_loaded;
    logic                     conv_complete;
    logic                     sample_complete;
    logic signed [ACC_W-1:0]  result;

    modport master (
        output frame_len,
        output load_coeff,
        output load_sample,
        output start_conv,
        output shift,
        output coeff_in,
        output coeff_valid,
        output sample_in,
        output sample_valid,
        input  coeff_loaded,
        input  sample_loaded,
        input  conv_complete,
        input  sample_complete,
        input  result
    );

    modport slave (
        input  frame_len,
        input  load_coeff,
        input  load_sample,
        input  start_conv,
        input  shift,
        input  coeff_in,
        input  coeff_valid,
        input  sample_in,
        input  sample_valid,
        output coeff_loaded,
        output sample_loaded,
        output conv_complete,
        output sample_complete,
        output result
    );

endinterface

// File: rtl/conv_mac_engine.sv
// conv_mac_engine: coefficient store, TAPS-deep sample window and a sequential
// multiply-accumulate engine that produces one result per window.
// Optional feature macro: CONV_SAT_EN clamps the result to the signed DATA_W range
// (sign-extended onto the result port); without it the full-precision sum is returned.
module conv_mac_engine #(
    parameter int TAPS   = 4,
    parameter int DATA_W = 8
) (
    input logic            clk,
    input logic            rst,
    conv_mac_engine_if.slave bus
);

    localparam int ACC_W  = 2 * DATA_W + $clog2(TAPS);
    localparam int PROD_W = 2 * DATA_W;
    localparam int IDX_W  = $clog2(TAPS + 1);
    localparam int K_W    = $clog2(TAPS);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(TAPS - 1);
    localparam logic [IDX_W-1:0] IDX_FULL = IDX_W'(TAPS);
    localparam logic [K_W-1:0]   K_LAST   = K_W'(TAPS - 1);

`ifdef CONV_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (DATA_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_MAC,
        S_DONE,
        S_WAIT_LOW
    } mac_state_e;

    logic signed [DATA_W-1:0] coeff_q [TAPS];
    logic signed [DATA_W-1:0] coeff_d [TAPS];
    logic        [IDX_W-1:0]  coeff_idx_q, coeff_idx_d;
    logic        [15:0]       frame_len_q, frame_len_d;
    logic                     load_coeff_prev_q, load_coeff_prev_d;
    logic                     coeff_loaded_q, coeff_loaded_d;

    logic signed [DATA_W-1:0] win_q [TAPS];
    logic signed [DATA_W-1:0] win_d [TAPS];
    logic        [IDX_W-1:0]  fill_cnt_q, fill_cnt_d;
    logic        [15:0]       consumed_q, consumed_d;
    logic                     shift_done_q, shift_done_d;
    logic                     load_sample_prev_q, load_sample_prev_d;
    logic                     sample_loaded_q, sample_loaded_d;
    logic                     sample_accept;

    mac_state_e               state_q, state_d;
    logic        [K_W-1:0]    k_q, k_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic signed [ACC_W-1:0]  result_q, result_d;
    logic                     conv_complete_q, conv_complete_d;

    logic                     load_coeff_act;
    logic                     load_sample_act;
    logic                     shift_act;
    logic                     frame_done;

    logic signed [PROD_W-1:0] coeff_ext;
    logic signed [PROD_W-1:0] win_ext;
    logic signed [PROD_W-1:0] product;
    logic signed [ACC_W-1:0]  product_ext;
    logic signed [ACC_W-1:0]  acc_sum;
    logic signed [ACC_W-1:0]  final_value;

    // Resolve overlapping controller strobes: coefficient load wins, then sample load, then shift.
    always_comb begin
        load_coeff_act  = bus.load_coeff;
        load_sample_act = bus.load_sample & ~bus.load_coeff;
        shift_act       = bus.shift & ~bus.load_coeff & ~bus.load_sample;
        frame_done      = (consumed_q >= frame_len_q);
    end

    // One product per MAC cycle, sign-extended so the running sum can never overflow.
    always_comb begin
        coeff_ext   = PROD_W'(coeff_q[k_q]);
        win_ext     = PROD_W'(win_q[k_q]);
        product     = coeff_ext * win_ext;
        product_ext = {{(ACC_W - PROD_W){product[PROD_W-1]}}, product};
        acc_sum     = acc_q + product_ext;
    end

`ifdef CONV_SAT_EN
    // Clamp the finished sum into the sample range before it is published.
    always_comb begin
        if (acc_sum > SAT_MAX) begin
            final_value = SAT_MAX;
        end else if (acc_sum < SAT_MIN) begin
            final_value = SAT_MIN;
        end else begin
            final_value = acc_sum;
        end
    end
`else
    // Publish the finished sum at full precision.
    always_comb begin
        final_value = acc_sum;
    end
`endif

    // Coefficient loading: restart the write index and latch frame_len when load_coeff rises.
    always_comb begin
        coeff_d           = coeff_q;
        coeff_idx_d       = coeff_idx_q;
        frame_len_d       = frame_len_q;
        coeff_loaded_d    = 1'b0;
        load_coeff_prev_d = load_coeff_act;
        if (load_coeff_act && !load_coeff_prev_q) begin
            coeff_idx_d = '0;
            frame_len_d = bus.frame_len;
        end
        if (load_coeff_act && bus.coeff_valid && (coeff_idx_d < IDX_FULL)) begin
            coeff_d[coeff_idx_d[K_W-1:0]] = bus.coeff_in;
            coeff_loaded_d                = (coeff_idx_d == IDX_LAST);
            coeff_idx_d                   = coeff_idx_d + 1'b1;
        end
    end

    // Sample window: initial fill during load_sample, one sample per shift state until the frame is consumed.
    always_comb begin
        win_d              = win_q;
        fill_cnt_d         = fill_cnt_q;
        consumed_d         = consumed_q;
        shift_done_d       = shift_done_q;
        sample_loaded_d    = 1'b0;
        sample_accept      = 1'b0;
        load_sample_prev_d = load_sample_act;
        if (load_sample_act) begin
            if (!load_sample_prev_q) begin
                fill_cnt_d = '0;
                consumed_d = '0;
            end
            if (bus.sample_valid) begin
                sample_accept = 1'b1;
                if (fill_cnt_d == IDX_LAST) begin
                    sample_loaded_d = 1'b1;
                end
                if (fill_cnt_d != IDX_FULL) begin
                    fill_cnt_d = fill_cnt_d + 1'b1;
                end
            end
        end else if (shift_act) begin
            if (!frame_done && !shift_done_q && bus.sample_valid) begin
                sample_accept   = 1'b1;
                sample_loaded_d = 1'b1;
                shift_done_d    = 1'b1;
            end
        end
        if (!shift_act) begin
            shift_done_d = 1'b0;
        end
        if (sample_accept) begin
            for (int i = TAPS - 1; i > 0; i--) begin
                win_d[i] = win_q[i-1];
            end
            win_d[0] = bus.sample_in;
            if (consumed_d != 16'hFFFF) begin
                consumed_d = consumed_d + 16'd1;
            end
        end
    end

    // MAC sequencing: clear on entry, TAPS accumulate cycles, one-cycle done pulse, then wait for start_conv to drop.
    always_comb begin
        state_d         = state_q;
        k_d             = k_q;
        acc_d           = acc_q;
        result_d        = result_q;
        conv_complete_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start_conv) begin
                    state_d = S_MAC;
                    k_d     = '0;
                    acc_d   = '0;
                end
            end
            S_MAC: begin
                if (!bus.start_conv) begin
                    state_d = S_IDLE;
                end else begin
                    acc_d = acc_sum;
                    k_d   = k_q + 1'b1;
                    if (k_q == K_LAST) begin
                        state_d         = S_DONE;
                        conv_complete_d = 1'b1;
                        result_d        = final_value;
                    end
                end
            end
            S_DONE: begin
                state_d = S_WAIT_LOW;
            end
            S_WAIT_LOW: begin
                if (!bus.start_conv) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Coefficient store and its bookkeeping registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < TAPS; i++) begin
                coeff_q[i] <= '0;
            end
            coeff_idx_q       <= '0;
            frame_len_q       <= '0;
            load_coeff_prev_q <= 1'b0;
            coeff_loaded_q    <= 1'b0;
        end else begin
            coeff_q           <= coeff_d;
            coeff_idx_q       <= coeff_idx_d;
            frame_len_q       <= frame_len_d;
            load_coeff_prev_q <= load_coeff_prev_d;
            coeff_loaded_q    <= coeff_loaded_d;
        end
    end

    // Sample window and its fill/consumption counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < TAPS; i++) begin
                win_q[i] <= '0;
            end
            fill_cnt_q         <= '0;
            consumed_q         <= '0;
            shift_done_q       <= 1'b0;
            load_sample_prev_q <= 1'b0;
            sample_loaded_q    <= 1'b0;
        end else begin
            win_q              <= win_d;
            fill_cnt_q         <= fill_cnt_d;
            consumed_q         <= consumed_d;
            shift_done_q       <= shift_done_d;
            load_sample_prev_q <= load_sample_prev_d;
            sample_loaded_q    <= sample_loaded_d;
        end
    end

    // MAC state machine registers together with its registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= S_IDLE;
            k_q             <= '0;
            acc_q           <= '0;
            result_q        <= '0;
            conv_complete_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            k_q             <= k_d;
            acc_q           <= acc_d;
            result_q        <= result_d;
            conv_complete_q <= conv_complete_d;
        end
    end

    assign bus.coeff_loaded    = coeff_loaded_q;
    assign bus.sample_loaded   = sample_loaded_q;
    assign bus.conv_complete   = conv_complete_q;
    assign bus.sample_complete = shift_act & frame_done;
    assign bus.result          = result_q;

endmodule

// File: tb/tb_conv_mac_engine.sv
// Self-checking bench for conv_mac_engine (TAPS=4, DATA_W=8).
// A spec-level model predicts every output each cycle; directed phases add literal checks.
module tb_conv_mac_engine;

    localparam int TAPS   = 4;
    localparam int DATA_W = 8;
    localparam int ACC_W  = 2 * DATA_W + $clog2(TAPS);

    logic clk = 1'b0;
    logic rst;

    int checks = 0;
    int errors = 0;

    conv_mac_engine_if #(.TAPS(TAPS), .DATA_W(DATA_W)) bus ();

    conv_mac_engine #(.TAPS(TAPS), .DATA_W(DATA_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    // Model state: coefficients, window (index 0 newest), counters and conversion progress.
    int   m_coeff [TAPS];
    int   m_win   [TAPS];
    int   m_idx      = 0;
    int   m_frame    = 0;
    int   m_consumed = 0;
    int   m_fill     = 0;
    int   m_age      = 0;
    bit   m_armed    = 1'b1;
    bit   m_took     = 1'b0;
    bit   m_prev_lc  = 1'b0;
    bit   m_prev_ls  = 1'b0;
    logic exp_cl     = 1'b0;
    logic exp_sl     = 1'b0;
    logic exp_cc     = 1'b0;
    int   exp_res    = 0;

    task automatic checkOutput(input string name, input logic signed [31:0] actual,
                               input logic signed [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic int model_result();
        int s = 0;
        for (int i = 0; i < TAPS; i++) begin
            s += m_coeff[i] * m_win[i];
        end
`ifdef CONV_SAT_EN
        if (s > 127) s = 127;
        else if (s < -128) s = -128;
`endif
        return s;
    endfunction

    // Model update on each clock edge, from the inputs as the DUT sees them.
    always @(posedge clk or posedge rst) begin
        bit lc, ls, sh, take;
        if (rst) begin
            for (int i = 0; i < TAPS; i++) begin
                m_coeff[i] = 0;
                m_win[i]   = 0;
            end
            m_idx = 0; m_frame = 0; m_consumed = 0; m_fill = 0; m_age = 0;
            m_armed = 1'b1; m_took = 1'b0; m_prev_lc = 1'b0; m_prev_ls = 1'b0;
            exp_cl = 1'b0; exp_sl = 1'b0; exp_cc = 1'b0; exp_res = 0;
        end else begin
            lc = bus.load_coeff;
            ls = bus.load_sample && !lc;
            sh = bus.shift && !lc && !ls;
            exp_cl = 1'b0;
            exp_sl = 1'b0;
            exp_cc = 1'b0;
            if (lc && !m_prev_lc) begin
                m_idx   = 0;
                m_frame = int'(bus.frame_len);
            end
            if (lc && bus.coeff_valid && m_idx < TAPS) begin
                m_coeff[m_idx] = int'(bus.coeff_in);
                m_idx++;
                if (m_idx == TAPS) exp_cl = 1'b1;
            end
            m_prev_lc = lc;
            take = 1'b0;
            if (ls) begin
                if (!m_prev_ls) begin
                    m_fill     = 0;
                    m_consumed = 0;
                end
                if (bus.sample_valid) begin
                    take = 1'b1;
                    m_fill++;
                    if (m_fill == TAPS) exp_sl = 1'b1;
                end
            end
            if (sh && !m_took && m_consumed < m_frame && bus.sample_valid) begin
                take   = 1'b1;
                m_took = 1'b1;
                exp_sl = 1'b1;
            end
            if (!sh) m_took = 1'b0;
            m_prev_ls = ls;
            if (take) begin
                for (int i = TAPS - 1; i > 0; i--) m_win[i] = m_win[i-1];
                m_win[0] = int'(bus.sample_in);
                m_consumed++;
            end
            if (!bus.start_conv) begin
                m_age   = 0;
                m_armed = 1'b1;
            end else if (m_armed) begin
                m_age++;
                if (m_age == TAPS + 1) begin
                    exp_cc  = 1'b1;
                    exp_res = model_result();
                    m_armed = 1'b0;
                    m_age   = 0;
                end
            end
        end
    end

    // Compare every output against the model in the middle of each cycle.
    always @(negedge clk) begin
        checkOutput("coeff_loaded", 32'(bus.coeff_loaded), 32'(exp_cl));
        checkOutput("sample_loaded", 32'(bus.sample_loaded), 32'(exp_sl));
        checkOutput("conv_complete", 32'(bus.conv_complete), 32'(exp_cc));
        checkOutput("sample_complete", 32'(bus.sample_complete),
                    32'(bus.shift && !bus.load_coeff && !bus.load_sample && (m_consumed >= m_frame)));
        checkOutput("result", 32'(bus.result), exp_res);
    end

    // Drive one cycle of controller inputs.
    task automatic applyStimulus(input logic lc, input logic ls, input logic sh, input logic sc,
                                 input logic cv, input logic signed [7:0] cin,
                                 input logic sv, input logic signed [7:0] sin);
        bus.load_coeff   = lc;
        bus.load_sample  = ls;
        bus.shift        = sh;
        bus.start_conv   = sc;
        bus.coeff_valid  = cv;
        bus.coeff_in     = cin;
        bus.sample_valid = sv;
        bus.sample_in    = sin;
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 8'sd0, 0, 8'sd0);
    endtask

    // Hold start_conv, measure latency to conv_complete and pin the result to a literal.
    task automatic runConv(input string name, input int expected);
        int  n = 0;
        bit  found = 1'b0;
        bus.start_conv = 1'b1;
        for (int i = 0; i < 20 && !found; i++) begin
            @(posedge clk);
            #2;
            n++;
            if (bus.conv_complete) found = 1'b1;
        end
        checkOutput({name, "_seen"}, 32'(found), 32'd1);
        checkOutput({name, "_latency"}, n, 32'd5);
        checkOutput({name, "_value"}, 32'(bus.result), expected);
        checkOutput({name, "_model"}, exp_res, expected);
        bus.start_conv = 1'b0;
        idleCycles(2);
    endtask

    task automatic countCompletes(input string name, input int cycles);
        int seen = 0;
        for (int i = 0; i < cycles; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 8'sd0, 0, 8'sd0);
            #2;
            if (bus.conv_complete) seen++;
        end
        checkOutput(name, seen, 32'd0);
    endtask

    // Directed sequence.
    initial begin
        rst = 1'b1;
        bus.frame_len = 16'd0;
        bus.load_coeff = 1'b0; bus.load_sample = 1'b0; bus.shift = 1'b0; bus.start_conv = 1'b0;
        bus.coeff_valid = 1'b0; bus.coeff_in = '0; bus.sample_valid = 1'b0; bus.sample_in = '0;
        repeat (2) @(posedge clk);
        #2;
        checkOutput("rst_coeff_loaded", 32'(bus.coeff_loaded), 32'd0);
        checkOutput("rst_conv_complete", 32'(bus.conv_complete), 32'd0);
        checkOutput("rst_result", 32'(bus.result), 32'd0);
        rst = 1'b0;
        idleCycles(2);

        // Coefficients 1..4 with a six-sample frame.
        bus.frame_len = 16'd6;
        for (int k = 1; k <= 4; k++) applyStimulus(1, 0, 0, 0, 1, 8'(k), 0, 8'sd0);
        #2;
        checkOutput("coeff_loaded_pulse", 32'(bus.coeff_loaded), 32'd1);
        idleCycles(1);

        // Window fill 1..4 (win = 4,3,2,1).
        for (int k = 1; k <= 4; k++) applyStimulus(0, 1, 0, 0, 0, 8'sd0, 1, 8'(k));
        #2;
        checkOutput("fill_sample_loaded", 32'(bus.sample_loaded), 32'd1);
        idleCycles(1);
        runConv("conv_first", 20);

        // Shift in 5; a second valid in the same shift state must be ignored.
        applyStimulus(0, 0, 1, 0, 0, 8'sd0, 1, 8'sd5);
        #2;
        checkOutput("shift5_sample_loaded", 32'(bus.sample_loaded), 32'd1);
        checkOutput("shift5_not_complete", 32'(bus.sample_complete), 32'd0);
        applyStimulus(0, 0, 1, 0, 0, 8'sd0, 1, 8'sd99);
        idleCycles(1);
        runConv("conv_shifted", 30);

        // Sixth sample, then the frame is exhausted.
        applyStimulus(0, 0, 1, 0, 0, 8'sd0, 1, 8'sd6);
        #2;
        checkOutput("shift6_sample_loaded", 32'(bus.sample_loaded), 32'd1);
        idleCycles(1);
        applyStimulus(0, 0, 1, 0, 0, 8'sd0, 1, 8'sd7);
        #2;
        checkOutput("frame_end_complete", 32'(bus.sample_complete), 32'd1);
        checkOutput("frame_end_no_load", 32'(bus.sample_loaded), 32'd0);
        idleCycles(1);

        // Abort after two MAC cycles: no pulse, result kept.
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 1, 0, 8'sd0, 0, 8'sd0);
        countCompletes("abort_no_complete", 8);
        checkOutput("abort_result_kept", 32'(bus.result), 32'd30);

        // Reset in the middle of a MAC run.
        for (int i = 0; i < 2; i++) applyStimulus(0, 0, 0, 1, 0, 8'sd0, 0, 8'sd0);
        rst = 1'b1;
        bus.start_conv = 1'b0;
        #1;
        checkOutput("midrst_result", 32'(bus.result), 32'd0);
        checkOutput("midrst_conv_complete", 32'(bus.conv_complete), 32'd0);
        checkOutput("midrst_sample_loaded", 32'(bus.sample_loaded), 32'd0);
        checkOutput("midrst_sample_complete", 32'(bus.sample_complete), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        countCompletes("midrst_no_complete", 8);

        // Extreme operands; the fifth and sixth coefficient writes must be dropped.
        bus.frame_len = 16'd100;
        for (int k = 0; k < 4; k++) applyStimulus(1, 0, 0, 0, 1, 8'sh80, 0, 8'sd0);
        applyStimulus(1, 0, 0, 0, 1, 8'sd7, 0, 8'sd0);
        #2;
        checkOutput("extra_coeff_no_pulse", 32'(bus.coeff_loaded), 32'd0);
        applyStimulus(1, 0, 0, 0, 1, 8'sd7, 0, 8'sd0);
        idleCycles(1);
        for (int k = 0; k < 4; k++) applyStimulus(0, 1, 0, 0, 0, 8'sd0, 1, 8'sh80);
        idleCycles(1);
`ifdef CONV_SAT_EN
        runConv("conv_extreme", 127);
`else
        runConv("conv_extreme", 65536);
`endif

        idleCycles(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Safety net so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] watchdog");
    end

endmodule
